// File: rtl/sram_stream_reader.sv
// Streams word_count consecutive SRAM words from base_addr onto a valid/ready port,
// holding off any read that would collide with the current or previous SRAM write.
module sram_stream_reader #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int COUNT_WIDTH = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [COUNT_WIDTH-1:0] word_count,
   output logic                   busy,
   output logic                   done,
   output logic [ADDR_WIDTH-1:0]  sram_read_address,
   input  logic [DATA_WIDTH-1:0]  sram_read_data,
   input  logic [ADDR_WIDTH-1:0]  snoop_write_address,
   input  logic                   snoop_write_enable,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last
);

   // state    | meaning
   // S_IDLE   | waiting for start
   // S_RUN    | issuing reads while credit allows and no write collides
   // S_DRAIN  | all reads issued, waiting for the last word to be popped
   // S_FINISH | zero-length transfer, pulse done next cycle
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [COUNT_WIDTH-1:0] issue_left_q, issue_left_d;
   logic [COUNT_WIDTH-1:0] pop_left_q, pop_left_d;
   logic                   done_q, done_d;
   logic                   pending_q;
   logic [ADDR_WIDTH-1:0]  wr_addr_q;
   logic                   wr_en_q;
   logic [DATA_WIDTH-1:0]  fifo_q [FIFO_DEPTH];
   logic [PW-1:0]          rd_ptr_q, wr_ptr_q;
   logic [PW:0]            fifo_count_q;
   logic                   hazard, credit, issue, push, pop;

   assign hazard = (wr_en_q && (wr_addr_q == addr_q)) ||
                   (snoop_write_enable && (snoop_write_address == addr_q));
   assign credit = (fifo_count_q + (PW+1)'(pending_q)) < DEPTH_C;
   assign issue  = (state_q == S_RUN) && (issue_left_q != '0) && credit && !hazard;
   assign push   = pending_q;
   assign pop    = out_valid && out_ready;

   assign out_valid         = (fifo_count_q != '0);
   assign out_data          = fifo_q[rd_ptr_q];
   assign out_last          = out_valid && (pop_left_q == COUNT_WIDTH'(1));
   assign busy              = (state_q != S_IDLE);
   assign done              = done_q;
   assign sram_read_address = addr_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      issue_left_d = issue_left_q;
      pop_left_d   = pop_left_q;
      done_d       = 1'b0;
      if (pop) begin
         pop_left_d = pop_left_q - COUNT_WIDTH'(1);
      end
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d       = base_addr;
               issue_left_d = word_count;
               pop_left_d   = word_count;
               state_d      = (word_count != '0) ? S_RUN : S_FINISH;
            end
         end
         S_RUN: begin
            if (issue) begin
               addr_d       = addr_q + ADDR_WIDTH'(1);
               issue_left_d = issue_left_q - COUNT_WIDTH'(1);
               if (issue_left_q == COUNT_WIDTH'(1)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Leaving on the final pop makes done and busy-low coincide next cycle.
            if (pop && (pop_left_q == COUNT_WIDTH'(1))) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         issue_left_q <= '0;
         pop_left_q   <= '0;
         done_q       <= 1'b0;
         pending_q    <= 1'b0;
         wr_addr_q    <= '0;
         wr_en_q      <= 1'b0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_left_q <= issue_left_d;
         pop_left_q   <= pop_left_d;
         done_q       <= done_d;
         pending_q    <= issue;
         wr_addr_q    <= snoop_write_address;
         wr_en_q      <= snoop_write_enable;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   fifo_count_q <= fifo_count_q + (PW+1)'(1);
            2'b01:   fifo_count_q <= fifo_count_q - (PW+1)'(1);
            default: fifo_count_q <= fifo_count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset && push) begin
         fifo_q[wr_ptr_q] <= sram_read_data;
      end
   end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed and randomized bench for sram_stream_reader with a behavioural SRAM
// that returns X on read-after-write collisions and a queue-based stream model.
module tb_sram_stream_reader;
   localparam int AW = 32;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int FD = 4;

   logic          clock = 1'b0;
   logic          reset, start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] word_count;
   logic          busy, done;
   logic [AW-1:0] sram_read_address;
   logic [DW-1:0] sram_read_data;
   logic [AW-1:0] snoop_write_address;
   logic          snoop_write_enable;
   logic [DW-1:0] snoop_write_data;
   logic [DW-1:0] out_data;
   logic          out_valid, out_ready, out_last;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   sram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .busy(busy), .done(done),
      .sram_read_address(sram_read_address), .sram_read_data(sram_read_data),
      .snoop_write_address(snoop_write_address), .snoop_write_enable(snoop_write_enable),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   // SRAM: 256 physical words, address high bits folded into the data so aliases differ.
   logic [DW-1:0] mem [256];
   logic [AW-1:0] prev_wa;
   logic          prev_we;

   function automatic logic [DW-1:0] mix(input logic [AW-1:0] a);
      return a[31:16] ^ {a[15:8], 8'h00};
   endfunction

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      return mem[a[7:0]] ^ mix(a);
   endfunction

   always @(posedge clock) begin
      if ((snoop_write_enable && snoop_write_address == sram_read_address) ||
          (prev_we && prev_wa == sram_read_address))
         sram_read_data <= 'x;
      else
         sram_read_data <= mem_rd(sram_read_address);
      if (snoop_write_enable)
         mem[snoop_write_address[7:0]] <= snoop_write_data ^ mix(snoop_write_address);
      prev_we <= snoop_write_enable;
      prev_wa <= snoop_write_address;
   end

   logic [DW-1:0] exp_q [$];
   int  pops = 0;
   bit  active = 0;
   bit  force_done = 0;
   bit  last_done = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      bit            popping, hold, want_done;
      logic [DW-1:0] held, tmp;
      popping   = (out_valid === 1'b1) && (out_ready === 1'b1);
      want_done = force_done;
      force_done = 0;
      if (popping) begin
         pops++;
         if (exp_q.size() == 0) chk("extra_pop", 1'b1, 1'b0);
         else begin
            chk("out_data", out_data, exp_q[0]);
            chk("out_last", out_last, exp_q.size() == 1);
            tmp = exp_q.pop_front();
            if (exp_q.size() == 0) want_done = 1;
         end
      end else if (out_valid === 1'b1) begin
         chk("out_last_idle", out_last, exp_q.size() == 1);
      end
      hold = (out_valid === 1'b1) && (out_ready === 1'b0) && (reset === 1'b1);
      held = out_data;
      @(posedge clock);
      #1;
      if (want_done) active = 0;
      if (hold) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_data", out_data, held);
      end
      chk("done", done, want_done);
      chk("busy", busy, active);
      chk("fifo_bound", dut.fifo_count_q <= 3'd4, 1'b1);
      last_done = done;
   endtask

   task automatic launch(input logic [AW-1:0] b, input logic [CW-1:0] n);
      for (int i = 0; i < int'(n); i++) exp_q.push_back(mem_rd(b + AW'(i)));
      base_addr  = b;
      word_count = n;
      start      = 1'b1;
      active     = 1;
      step();
      start      = 1'b0;
   endtask

   // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready
   task automatic run(input int mode, input bit hz, input int budget, output int n);
      logic [AW-1:0] a;
      n = 0;
      last_done = 0;
      while (!last_done && n < budget) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((n % 4) == 0) || ((n % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (hz && $urandom_range(0, 2) == 0) begin
            a = sram_read_address + AW'($urandom_range(0, 2));
            snoop_write_address = a;
            snoop_write_data    = mem_rd(a);
            snoop_write_enable  = 1'b1;
         end else begin
            snoop_write_enable = 1'b0;
         end
         step();
         n++;
      end
      snoop_write_enable = 1'b0;
      if (!last_done) chk("done_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      int            n, p0;
      logic [DW-1:0] pre [4];

      reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
      out_ready = 1'b0; snoop_write_enable = 1'b0;
      snoop_write_address = '0; snoop_write_data = '0;

      // fill memory through the write port while the reader is held in reset
      for (int i = 0; i < 256; i++) begin
         snoop_write_enable  = 1'b1;
         snoop_write_address = AW'(i);
         snoop_write_data    = DW'($urandom);
         step();
      end
      snoop_write_enable = 1'b0;
      step();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_addr", sram_read_address, 32'h0);
      reset = 1'b1;

      // basic: preload 0x10..0x13
      for (int i = 0; i < 4; i++) begin
         pre[i] = DW'($urandom);
         snoop_write_enable  = 1'b1;
         snoop_write_address = 32'h10 + AW'(i);
         snoop_write_data    = pre[i];
         step();
      end
      snoop_write_enable = 1'b0;
      step(); step();
      out_ready = 1'b1;
      launch(32'h10, 4);
      chk("basic_addr0", sram_read_address, 32'h10);
      step();
      chk("basic_addr1", sram_read_address, 32'h11);
      chk("basic_early", out_valid, 1'b0);
      step();
      chk("basic_valid", out_valid, 1'b1);
      chk("basic_A", out_data, pre[0]);
      run(0, 0, 50, n);
      chk("basic_cycles", n, 4);

      // backpressure 1,0,0,1
      p0 = pops;
      launch(32'h80 + AW'($urandom_range(0, 31)), 8);
      run(1, 0, 200, n);
      chk("bp_pops", pops - p0, 8);

      // read-after-write on 0x20
      out_ready = 1'b1;
      launch(32'h20, 2);
      exp_q[0] = 16'h0055;
      snoop_write_enable  = 1'b1;
      snoop_write_address = 32'h20;
      snoop_write_data    = 16'h0055;
      step();
      snoop_write_enable = 1'b0;
      chk("raw_stall1", sram_read_address, 32'h20);
      step();
      chk("raw_stall2", sram_read_address, 32'h20);
      step();
      chk("raw_issued", sram_read_address, 32'h21);
      chk("raw_valid_early", out_valid, 1'b0);
      run(0, 0, 50, n);

      // address wrap
      launch(32'hFFFF_FFFE, 4);
      chk("wrap_a0", sram_read_address, 32'hFFFF_FFFE);
      step();
      chk("wrap_a1", sram_read_address, 32'hFFFF_FFFF);
      step();
      chk("wrap_a2", sram_read_address, 32'h0);
      step();
      chk("wrap_a3", sram_read_address, 32'h1);
      run(0, 0, 50, n);

      // zero-length transfer
      launch(32'h55, 0);
      chk("zero_valid1", out_valid, 1'b0);
      force_done = 1;
      step();
      chk("zero_valid2", out_valid, 1'b0);
      step();
      chk("zero_valid3", out_valid, 1'b0);

      // reset after 5 pops of a 16-word transfer
      p0 = pops;
      launch(32'h30, 16);
      n = 0;
      while ((pops - p0) < 5 && n < 200) begin
         out_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      chk("rst_pops", pops - p0, 5);
      out_ready = 1'b0;
      reset = 1'b0;
      exp_q.delete();
      active = 0;
      step();
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_fifo", dut.fifo_count_q, 3'd0);
      reset = 1'b1;
      out_ready = 1'b1;
      p0 = pops;
      launch(32'h40, 2);
      run(0, 0, 50, n);
      chk("midrst_new_pops", pops - p0, 2);

      // start while busy is ignored
      p0 = pops;
      launch(32'h1200 + AW'($urandom_range(0, 255)), 6);
      step(); step();
      start = 1'b1; base_addr = 32'h300; word_count = 3;
      step();
      start = 1'b0;
      run(2, 1, 300, n);
      out_ready = 1'b1;
      step(); step(); step();
      chk("busy_start_pops", pops - p0, 6);

      // random back-to-back transfers with random backpressure and collisions
      for (int k = 0; k < 6; k++) begin
         p0 = pops;
         launch(AW'($urandom), CW'($urandom_range(1, 12)));
         n = exp_q.size();
         run(2, 1, 400, n);
         chk("rand_empty", exp_q.size(), 0);
      end
      out_ready = 1'b1;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
